stream_mux_rr: RTL

- Parametrised N-to-1 stream multiplexer.
- Successor to the team's fixed 2:1 and 3:1 combinational muxes.
- Adds valid/ready handshakes on every channel, a registered output stage, and a runtime mode select: fixed-select (classic mux) or round-robin arbitration.
- Sits between multiple producers (e.g. register-file write sources, memory/IO return paths) and one consumer in the 16-bit datapath.

---
 rtl/stream_mux_rr.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-to-1 valid/ready stream mux, fixed-select or round-robin.
// Define STREAM_MUX_LOCK_EN for in_last/out_last and packet-locked arbitration.
module stream_mux_rr #(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
`ifdef STREAM_MUX_LOCK_EN
  input  logic [N-1:0]       in_last,
  output logic               out_last,
`endif
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_chan
);

  if (SELW != $clog2(N) || N < 2 || N > 16) begin : g_param_chk
    $error("stream_mux_rr: need 2<=N<=16 and SELW==clog2(N)");
  end

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_chan_q, out_chan_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

  logic             rr_hit;
  logic [SELW-1:0]  rr_idx;
  logic             grant_present;
  logic [SELW-1:0]  grant_idx;
  logic             load_ok;
  logic             xfer;
  logic             is_last;

`ifdef STREAM_MUX_LOCK_EN
  logic             lock_q, lock_d;
  logic [SELW-1:0]  lock_chan_q, lock_chan_d;
  logic             out_last_q, out_last_d;
`endif

  // Highest offset first so the lowest offset from rr_ptr wins.
  always_comb begin : rr_search
    int c;
    c      = 0;
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(rr_ptr_q) + k;
      if (c >= N) c = c - N;
      if (in_valid[c[SELW-1:0]]) begin
        rr_hit = 1'b1;
        rr_idx = c[SELW-1:0];
      end
    end
  end

  always_comb begin
    grant_present = 1'b0;
    grant_idx     = '0;
    if (!mode) begin
      grant_present = (int'(sel) < N);
      grant_idx     = sel;
    end
`ifdef STREAM_MUX_LOCK_EN
    else if (lock_q) begin
      grant_present = in_valid[lock_chan_q];
      grant_idx     = lock_chan_q;
    end
`endif
    else begin
      grant_present = rr_hit;
      grant_idx     = rr_idx;
    end
  end

  assign load_ok = !out_valid_q || out_ready;

  // Gated by rst_n so no handshake completes while reset is held.
  assign in_ready = (rst_n && grant_present && load_ok)
                  ? (N'(1) << grant_idx) : '0;

  assign xfer = |(in_ready & in_valid);

`ifdef STREAM_MUX_LOCK_EN
  assign is_last = in_last[grant_idx];
`else
  assign is_last = 1'b1;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(grant_idx)*WIDTH +: WIDTH];
      out_chan_d  = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (xfer && mode && is_last) begin
      rr_ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end

`ifdef STREAM_MUX_LOCK_EN
  always_comb begin
    lock_d      = lock_q;
    lock_chan_d = lock_chan_q;
    out_last_d  = out_last_q;
    if (xfer) out_last_d = is_last;
    if (!mode) begin
      lock_d = 1'b0;
    end else if (xfer) begin
      lock_d      = !is_last;
      lock_chan_d = grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q      <= 1'b0;
      lock_chan_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      lock_q      <= lock_d;
      lock_chan_q <= lock_chan_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_last = out_last_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule
